regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 136 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters for an in-order issue scoreboard.
// Latency: combinational reads, writes/counter updates visible after the rising edge.
// Backpressure: issue_ready_o drops when a register already has MAXPEND claims.
// Optional REGFILE_SB_BYPASS_EN forwards same-cycle writeback data to the read ports.
package regfile_sb_pkg;
  localparam logic [31:0] STACK_TOP = 32'h0000_FFF0;
endpackage

module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int                DWIDTH  = 32,
  parameter int                NREGS   = 32,
  parameter int                NRD     = 2,
  parameter int                MAXPEND = 3,
  parameter logic [DWIDTH-1:0] SP_INIT = DWIDTH'(STACK_TOP),
  localparam int               AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rs_addr_i,
  output logic [NRD*DWIDTH-1:0] rs_data_o,
  output logic [NRD-1:0]        rs_busy_o,
  input  logic                  issue_valid_i,
  input  logic [AW-1:0]         issue_rd_i,
  output logic                  issue_ready_o,
  input  logic                  wb0_valid_i,
  input  logic [AW-1:0]         wb0_rd_i,
  input  logic [DWIDTH-1:0]     wb0_data_i,
  input  logic                  wb1_valid_i,
  input  logic [AW-1:0]         wb1_rd_i,
  input  logic [DWIDTH-1:0]     wb1_data_i,
  output logic                  err_o
);

  localparam int            PW   = $clog2(MAXPEND + 1);
  localparam logic [PW-1:0] PMAX = PW'(MAXPEND);

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [PW-1:0]     pend_q [NREGS];
  logic [PW-1:0]     pend_d [NREGS];
  logic              err_q, err_d;
  logic              issue_fire;

  // Result packs {underflow, new count}; underflow pins the count at zero.
  function automatic logic [PW:0] pend_step(input logic [PW-1:0] cur,
                                            input logic          inc,
                                            input logic [1:0]    dec);
    logic [PW+1:0] up;
    logic [PW+1:0] dn;
    up = {2'b00, cur} + {{(PW+1){1'b0}}, inc};
    dn = {{PW{1'b0}}, dec};
    if (up < dn) begin
      pend_step = {1'b1, {PW{1'b0}}};
    end else begin
      pend_step = {1'b0, PW'(up - dn)};
    end
  endfunction

  assign issue_ready_o = !((issue_rd_i != '0) && (pend_q[issue_rd_i] == PMAX));
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != '0);
  assign err_o         = err_q;

  always_comb begin
    logic          inc;
    logic [1:0]    dec;
    logic [PW:0]   res;
    pend_d = pend_q;
    err_d  = err_q;
    inc    = 1'b0;
    dec    = 2'b00;
    res    = '0;
    pend_d[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      inc = issue_fire && (issue_rd_i == AW'(r));
      dec = {1'b0, wb0_valid_i && (wb0_rd_i == AW'(r))}
          + {1'b0, wb1_valid_i && (wb1_rd_i == AW'(r))};
      res = pend_step(pend_q[r], inc, dec);
      pend_d[r] = res[PW-1:0];
      if (res[PW]) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= (r == 2) ? SP_INIT : '0;
        pend_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
      // wb1 is written last so it wins when both ports hit one register.
      if (wb0_valid_i && (wb0_rd_i != '0)) begin
        regs_q[wb0_rd_i] <= wb0_data_i;
      end
      if (wb1_valid_i && (wb1_rd_i != '0)) begin
        regs_q[wb1_rd_i] <= wb1_data_i;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DWIDTH-1:0] rdat;
    logic              busy;

    assign addr = rs_addr_i[k*AW +: AW];

    always_comb begin
      rdat = regs_q[addr];
      busy = (pend_q[addr] != '0);
      if (addr == '0) begin
        rdat = '0;
        busy = 1'b0;
      end
`ifdef REGFILE_SB_BYPASS_EN
      else begin
        if (wb0_valid_i && (wb0_rd_i == addr)) begin
          rdat = wb0_data_i;
        end
        if (wb1_valid_i && (wb1_rd_i == addr)) begin
          rdat = wb1_data_i;
        end
      end
`endif
    end

    assign rs_data_o[k*DWIDTH +: DWIDTH] = rdat;
    assign rs_busy_o[k]                  = busy;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed + random bench for regfile_scoreboard against an array/integer reference model.
module tb_regfile_scoreboard;
  localparam int          DW   = 32;
  localparam int          NR   = 32;
  localparam int          NRD  = 2;
  localparam int          AW   = 5;
  localparam int          MAXP = 3;
  localparam logic [31:0] SP   = 32'h8000_0F00;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rs_addr;
  logic [NRD*DW-1:0] rs_data;
  logic [NRD-1:0]    rs_busy;
  logic              issue_v;
  logic [AW-1:0]     issue_rd;
  logic              issue_ready;
  logic              wb0_v, wb1_v;
  logic [AW-1:0]     wb0_rd, wb1_rd;
  logic [DW-1:0]     wb0_d, wb1_d;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg [NR];
  int          m_pend [NR];
  bit          m_err;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DWIDTH(DW), .NREGS(NR), .NRD(NRD), .MAXPEND(MAXP), .SP_INIT(SP)) dut (
    .clk(clk), .rst(rst),
    .rs_addr_i(rs_addr), .rs_data_o(rs_data), .rs_busy_o(rs_busy),
    .issue_valid_i(issue_v), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
    .wb0_valid_i(wb0_v), .wb0_rd_i(wb0_rd), .wb0_data_i(wb0_d),
    .wb1_valid_i(wb1_v), .wb1_rd_i(wb1_rd), .wb1_data_i(wb1_d),
    .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_reg[r]  = 32'h0;
      m_pend[r] = 0;
    end
    m_reg[2] = SP;
    m_err    = 1'b0;
  endtask

  function automatic logic [31:0] exp_read(input logic [AW-1:0] a);
    logic [31:0] v;
    if (a == '0) return 32'h0;
    v = m_reg[a];
`ifdef REGFILE_SB_BYPASS_EN
    if (wb0_v && wb0_rd == a) v = wb0_d;
    if (wb1_v && wb1_rd == a) v = wb1_d;
`endif
    return v;
  endfunction

  function automatic bit exp_ready();
    return !(issue_rd != '0 && m_pend[issue_rd] == MAXP);
  endfunction

  task automatic model_update();
    int net [NR];
    bit rdy;
    rdy = exp_ready();
    for (int r = 0; r < NR; r++) net[r] = m_pend[r];
    if (issue_v && rdy && issue_rd != '0) net[issue_rd] = net[issue_rd] + 1;
    if (wb0_v && wb0_rd != '0) begin
      net[wb0_rd] = net[wb0_rd] - 1;
      m_reg[wb0_rd] = wb0_d;
    end
    if (wb1_v && wb1_rd != '0) begin
      net[wb1_rd] = net[wb1_rd] - 1;
      m_reg[wb1_rd] = wb1_d;
    end
    for (int r = 0; r < NR; r++) begin
      if (net[r] < 0) begin
        m_err     = 1'b1;
        m_pend[r] = 0;
      end else begin
        m_pend[r] = net[r];
      end
    end
  endtask

  // Check combinational outputs mid-cycle, then take one clock edge.
  task automatic step(input string tag);
    @(negedge clk);
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] a;
      a = rs_addr[k*AW +: AW];
      chk({tag, "_data"}, 64'(rs_data[k*DW +: DW]), 64'(exp_read(a)));
      chk({tag, "_busy"}, 64'(rs_busy[k]), 64'(a != '0 && m_pend[a] != 0));
    end
    chk({tag, "_ready"}, 64'(issue_ready), 64'(exp_ready()));
    chk({tag, "_err"}, 64'(err), 64'(m_err));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    issue_v = 1'b0; issue_rd = '0;
    wb0_v = 1'b0; wb0_rd = '0; wb0_d = '0;
    wb1_v = 1'b0; wb1_rd = '0; wb1_d = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    rs_addr = {a1, a0};
  endtask

  initial begin
    rst = 1'b0;
    idle();
    set_rd(5'd0, 5'd0);
    model_reset();
    #12;
    set_rd(5'd5, 5'd2);
    issue_rd = 5'd5;
    #1;
    chk("inrst_x2", 64'(rs_data[31:0]), 64'(SP));
    chk("inrst_x5", 64'(rs_data[63:32]), 64'h0);
    chk("inrst_busy", 64'(rs_busy), 64'h0);
    chk("inrst_ready", 64'(issue_ready), 64'h1);
    chk("inrst_err", 64'(err), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    issue_rd = '0;
    step("rst_read");

    // Fill x5 to the claim limit, then attempt one more.
    issue_v = 1'b1; issue_rd = 5'd5; set_rd(5'd5, 5'd5);
    step("iss5_a"); step("iss5_b"); step("iss5_c");
    chk("iss5_full_ready", 64'(issue_ready), 64'h0);
    step("iss5_d");
    idle(); issue_rd = 5'd5;
    #1;
    chk("iss5_busy", 64'(rs_busy[0]), 64'h1);
    chk("iss5_still_full", 64'(issue_ready), 64'h0);
    step("iss5_hold");

    // Two claims on x7 retired together; wb1 data wins.
    idle(); issue_v = 1'b1; issue_rd = 5'd7; set_rd(5'd7, 5'd7);
    step("iss7_a"); step("iss7_b");
    idle();
    wb0_v = 1'b1; wb0_rd = 5'd7; wb0_d = 32'hAAAA_0000;
    wb1_v = 1'b1; wb1_rd = 5'd7; wb1_d = 32'h1234_5678;
    step("wb7_both");
    idle();
    #1;
    chk("wb7_data", 64'(rs_data[31:0]), 64'h1234_5678);
    chk("wb7_busy", 64'(rs_busy[0]), 64'h0);
    chk("wb7_noerr", 64'(err), 64'h0);
    step("wb7_after");

    // Unclaimed writeback to x9.
    wb0_v = 1'b1; wb0_rd = 5'd9; wb0_d = 32'h0909_0909; set_rd(5'd9, 5'd9);
    step("wb9");
    idle();
    #1;
    chk("wb9_data", 64'(rs_data[31:0]), 64'h0909_0909);
    chk("wb9_err", 64'(err), 64'h1);
    step("wb9_s1"); step("wb9_s2");
    chk("wb9_err_sticky", 64'(err), 64'h1);

    // Same-cycle read of a register being written.
    wb0_v = 1'b1; wb0_rd = 5'd3; wb0_d = 32'hDEAD_BEEF; set_rd(5'd3, 5'd3);
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    chk("byp_same", 64'(rs_data[31:0]), 64'hDEAD_BEEF);
`else
    chk("byp_same", 64'(rs_data[31:0]), 64'h0);
`endif
    step("wb3");
    idle();
    #1;
    chk("wb3_next", 64'(rs_data[31:0]), 64'hDEAD_BEEF);
    step("wb3_after");

    // Reset asserted mid-cycle with a claim in flight.
    issue_v = 1'b1; issue_rd = 5'd4; set_rd(5'd4, 5'd3);
    step("iss4");
    idle(); set_rd(5'd4, 5'd2);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_x2", 64'(rs_data[31:0]), 64'(SP));
    chk("mid_rst_busy4", 64'(rs_busy[1]), 64'h0);
    chk("mid_rst_err", 64'(err), 64'h0);
    set_rd(5'd3, 5'd0);
    wb0_v = 1'b1; wb0_rd = 5'd0; wb0_d = 32'hFFFF_FFFF;
    #1;
    chk("mid_rst_x3", 64'(rs_data[63:32]), 64'h0);
    chk("mid_rst_x0", 64'(rs_data[31:0]), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    wb1_v = 1'b1; wb1_rd = 5'd6; wb1_d = 32'h0000_0066; set_rd(5'd6, 5'd0);
    step("post_rst_wb");
    idle();
    #1;
    chk("post_rst_x6", 64'(rs_data[63:32]), 64'h66);
    chk("post_rst_x0", 64'(rs_data[31:0]), 64'h0);
    step("post_rst_after");

    // Random traffic on a small register window to force collisions.
    rst = 1'b0; model_reset(); #1;
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 600; i++) begin
      set_rd(AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9)));
      issue_v  = ($urandom_range(0, 2) != 0);
      issue_rd = AW'($urandom_range(0, 7));
      wb0_v    = ($urandom_range(0, 2) == 0);
      wb0_rd   = AW'($urandom_range(0, 7));
      wb0_d    = $urandom;
      wb1_v    = ($urandom_range(0, 3) == 0);
      wb1_rd   = AW'($urandom_range(0, 7));
      wb1_d    = $urandom;
      if (i == 300) begin
        idle();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rnd_rst_err", 64'(err), 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
      end else begin
        step("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
